// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache fetch controller.
// Holds the controller state encoding, the NOP instruction returned on
// non-hit cycles, default geometry, and a helper for the tag width.
package icache_pkg;

    localparam int unsigned ADDR_W              = 32;
    localparam int unsigned DATA_W              = 32;
    localparam int unsigned NUM_LINES_DEF       = 16;
    localparam int unsigned WORDS_PER_LINE_DEF  = 4;

    localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        IDLE,
        REFILL
    } state_t;

    // Word-aligned address: 30 significant bits split into tag/index/offset.
    function automatic int unsigned tag_width(input int unsigned idx_w,
                                              input int unsigned off_w);
        return 30 - idx_w - off_w;
    endfunction

    localparam int unsigned IDX_W_DEF = $clog2(NUM_LINES_DEF);
    localparam int unsigned OFF_W_DEF = $clog2(WORDS_PER_LINE_DEF);
    localparam int unsigned TAG_W_DEF = tag_width(IDX_W_DEF, OFF_W_DEF);

endpackage

// File: rtl/icache_data_array.sv
// Direct-mapped storage for the instruction cache: per-line valid bit,
// tag and data words.
// Ports:
//   clk, rst           clock, asynchronous active-high reset (clears valid)
//   rd_idx, rd_word    combinational read address
//   rd_valid, rd_tag   valid bit and tag of line rd_idx
//   rd_data            word rd_word of line rd_idx
//   wr_en              write wr_data into line wr_idx, word wr_word
//   tag_we             write wr_tag into line wr_idx and mark it valid
//   flush              clear every valid bit at the next edge (wins over tag_we)
module icache_data_array
    import icache_pkg::*;
#(
    parameter  int unsigned NUM_LINES      = NUM_LINES_DEF,
    parameter  int unsigned WORDS_PER_LINE = WORDS_PER_LINE_DEF,
    localparam int unsigned IDX_W          = $clog2(NUM_LINES),
    localparam int unsigned OFF_W          = $clog2(WORDS_PER_LINE),
    localparam int unsigned TAG_W          = tag_width(IDX_W, OFF_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [OFF_W-1:0]  rd_word,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [OFF_W-1:0]  wr_word,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              tag_we,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic              flush
);

    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
    logic [DATA_W-1:0]    data_arr [NUM_LINES][WORDS_PER_LINE];

    // Flush takes priority so a line completing alongside a fence stays invalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (tag_we) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_arr[wr_idx][wr_word] <= wr_data;
        end
        if (tag_we) begin
            tag_arr[wr_idx] <= wr_tag;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tag_arr[rd_idx];
    assign rd_data  = data_arr[rd_idx][rd_word];

endmodule

// File: rtl/icache_fetch_ctrl.sv
// Instruction-cache fetch controller. Serves the fetch PC from a
// direct-mapped cache with zero-cycle hit latency, stalls fetch on a miss
// and refills the whole line from main memory starting at word 0.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   PC              fetch address (bits [1:0] ignored)
//   fence_i         one-cycle pulse: invalidate the whole cache
//   instr, stall    instruction for PC, valid when stall = 0
//   mem_req         refill request, held for the whole line
//   mem_addr        word-aligned address of the current refill beat
//   mem_rdata       refill data, sampled when mem_ready = 1
//   mem_ready       one refill beat transferred this cycle
module icache_fetch_ctrl
    import icache_pkg::*;
#(
    parameter int unsigned NUM_LINES      = NUM_LINES_DEF,
    parameter int unsigned WORDS_PER_LINE = WORDS_PER_LINE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] PC,
    input  logic              fence_i,
    output logic [DATA_W-1:0] instr,
    output logic              stall,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int unsigned IDX_W = $clog2(NUM_LINES);
    localparam int unsigned OFF_W = $clog2(WORDS_PER_LINE);
    localparam int unsigned TAG_W = tag_width(IDX_W, OFF_W);

    logic [OFF_W-1:0] pc_word;
    logic [IDX_W-1:0] pc_idx;
    logic [TAG_W-1:0] pc_tag;
    logic             unused_pc_bits;

    assign pc_word        = PC[OFF_W+1:2];
    assign pc_idx         = PC[OFF_W+IDX_W+1:OFF_W+2];
    assign pc_tag         = PC[ADDR_W-1:OFF_W+IDX_W+2];
    assign unused_pc_bits = ^PC[1:0];

    state_t           state;
    logic [OFF_W-1:0] cnt;
    logic [TAG_W-1:0] miss_tag;
    logic [IDX_W-1:0] miss_idx;
    logic             fence_pend;

    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [DATA_W-1:0] rd_data;
    logic              hit;
    logic              beat;
    logic              last_beat;
    logic              flush;

    assign hit       = (state == IDLE) && rd_valid && (rd_tag == pc_tag);
    // mem_ready outside an active request is ignored.
    assign beat      = mem_req && mem_ready;
    assign last_beat = beat && (cnt == OFF_W'(WORDS_PER_LINE - 1));
    // A fence seen during refill (pending or on the final beat) wipes the
    // new line too, as the cache drops back to IDLE.
    assign flush     = ((state == IDLE) && fence_i) ||
                       (last_beat && (fence_pend || fence_i));

    icache_data_array #(
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (pc_idx),
        .rd_word  (pc_word),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (beat),
        .wr_idx   (miss_idx),
        .wr_word  (cnt),
        .wr_data  (mem_rdata),
        .tag_we   (last_beat),
        .wr_tag   (miss_tag),
        .flush    (flush)
    );

    assign stall    = rst || !hit;
    assign instr    = (!rst && hit) ? rd_data : NOP_INSTR;
    assign mem_addr = {miss_tag, miss_idx, cnt, 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            miss_tag   <= '0;
            miss_idx   <= '0;
            mem_req    <= 1'b0;
            fence_pend <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!hit) begin
                        miss_tag <= pc_tag;
                        miss_idx <= pc_idx;
                        cnt      <= '0;
                        mem_req  <= 1'b1;
                        state    <= REFILL;
                    end
                end
                REFILL: begin
                    if (fence_i) begin
                        fence_pend <= 1'b1;
                    end
                    if (beat) begin
                        cnt <= cnt + 1'b1;
                        if (last_beat) begin
                            mem_req    <= 1'b0;
                            fence_pend <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// Directed self-checking bench for icache_fetch_ctrl. Memory returns
// {16'hC0DE, addr[15:0]} for every refill beat. Inputs change 1 ns after
// the rising edge; outputs are checked on the falling edge.
module tb_icache_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] PC;
    logic        fence_i;
    logic [31:0] instr;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int checks = 0;
    int errors = 0;

    icache_fetch_ctrl #(
        .NUM_LINES      (16),
        .WORDS_PER_LINE (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .PC        (PC),
        .fence_i   (fence_i),
        .instr     (instr),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign mem_rdata = {16'hC0DE, mem_addr[15:0]};

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach summary");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Drives the remaining beats of a refill with no gaps (no checking).
    task automatic finish_refill(input int unsigned beats);
        for (int unsigned i = 0; i < beats; i++) begin
            mem_ready = 1'b1;
            step();
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; PC = 32'h0; fence_i = 1'b0; mem_ready = 1'b0;
        sample();
        checks++;
        if ({stall, mem_req, instr, mem_addr} !== {1'b1, 1'b0, NOP, 32'h0}) begin
            errors++;
            $display("FAIL reset: stall/req/instr/addr got %b %b %h %h exp 1 0 %h 0",
                     stall, mem_req, instr, mem_addr, NOP);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_first_fill();
        PC = 32'h0000_0000;
        sample();
        checks++;
        if ({stall, mem_req, instr} !== {1'b1, 1'b0, NOP}) begin
            errors++;
            $display("FAIL t1_miss: stall/req/instr got %b %b %h exp 1 0 %h", stall, mem_req, instr, NOP);
        end
        step();
        for (int unsigned b = 0; b < 4; b++) begin
            mem_ready = 1'b1;
            sample();
            checks++;
            if ({stall, mem_req, mem_addr} !== {1'b1, 1'b1, 32'(b * 4)}) begin
                errors++;
                $display("FAIL t1_beat%0d: stall/req/addr got %b %b %h exp 1 1 %h",
                         b, stall, mem_req, mem_addr, 32'(b * 4));
            end
            step();
        end
        mem_ready = 1'b0;
        sample();
        checks++;
        if ({stall, mem_req, instr} !== {1'b0, 1'b0, 32'hC0DE_0000}) begin
            errors++;
            $display("FAIL t1_hit: stall/req/instr got %b %b %h exp 0 0 c0de0000", stall, mem_req, instr);
        end
        step();
    endtask

    task automatic test_hit();
        PC = 32'h0000_0008;
        mem_ready = 1'b1;   // stray ready with no request must be ignored
        sample();
        checks++;
        if ({stall, mem_req, instr} !== {1'b0, 1'b0, 32'hC0DE_0008}) begin
            errors++;
            $display("FAIL t2_hit: stall/req/instr got %b %b %h exp 0 0 c0de0008", stall, mem_req, instr);
        end
        step();
        mem_ready = 1'b0;
        PC = 32'h0000_0004;
        sample();
        checks++;
        if ({stall, mem_req, instr} !== {1'b0, 1'b0, 32'hC0DE_0004}) begin
            errors++;
            $display("FAIL t2_hit_w1: stall/req/instr got %b %b %h exp 0 0 c0de0004", stall, mem_req, instr);
        end
        step();
    endtask

    task automatic test_replace();
        PC = 32'h0000_1000;
        sample();
        checks++;
        if ({stall, instr} !== {1'b1, NOP}) begin
            errors++;
            $display("FAIL t3_miss: stall/instr got %b %h exp 1 %h", stall, instr, NOP);
        end
        step();
        for (int unsigned b = 0; b < 4; b++) begin
            mem_ready = 1'b1;
            sample();
            checks++;
            if ({mem_req, mem_addr} !== {1'b1, 32'h1000 + 32'(b * 4)}) begin
                errors++;
                $display("FAIL t3_beat%0d: req/addr got %b %h exp 1 %h",
                         b, mem_req, mem_addr, 32'h1000 + 32'(b * 4));
            end
            step();
        end
        mem_ready = 1'b0;
        PC = 32'h0000_100C;
        sample();
        checks++;
        if ({stall, instr} !== {1'b0, 32'hC0DE_100C}) begin
            errors++;
            $display("FAIL t3_hit: stall/instr got %b %h exp 0 c0de100c", stall, instr);
        end
        step();
        PC = 32'h0000_0000;
        sample();
        checks++;
        if ({stall, instr, mem_req} !== {1'b1, NOP, 1'b0}) begin
            errors++;
            $display("FAIL t3_old_miss: stall/instr/req got %b %h %b exp 1 %h 0", stall, instr, mem_req, NOP);
        end
        step();
        finish_refill(4);
        sample();
        checks++;
        if ({stall, instr} !== {1'b0, 32'hC0DE_0000}) begin
            errors++;
            $display("FAIL t3_refetch: stall/instr got %b %h exp 0 c0de0000", stall, instr);
        end
        step();
    endtask

    task automatic test_gapped();
        PC = 32'h0000_0040;
        sample();
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL t4_miss: stall got %b exp 1", stall);
        end
        step();
        for (int unsigned b = 0; b < 4; b++) begin
            for (int unsigned g = 0; g < 3; g++) begin
                mem_ready = (g == 2);
                sample();
                checks++;
                if ({stall, mem_req, mem_addr} !== {1'b1, 1'b1, 32'h40 + 32'(b * 4)}) begin
                    errors++;
                    $display("FAIL t4_beat%0d_c%0d: stall/req/addr got %b %b %h exp 1 1 %h",
                             b, g, stall, mem_req, mem_addr, 32'h40 + 32'(b * 4));
                end
                step();
            end
        end
        mem_ready = 1'b0;
        PC = 32'h0000_0044;
        sample();
        checks++;
        if ({stall, mem_req, instr} !== {1'b0, 1'b0, 32'hC0DE_0044}) begin
            errors++;
            $display("FAIL t4_hit_w1: stall/req/instr got %b %b %h exp 0 0 c0de0044", stall, mem_req, instr);
        end
        step();
        PC = 32'h0000_004C;
        sample();
        checks++;
        if ({stall, instr} !== {1'b0, 32'hC0DE_004C}) begin
            errors++;
            $display("FAIL t4_hit_w3: stall/instr got %b %h exp 0 c0de004c", stall, instr);
        end
        step();
    endtask

    task automatic test_fence();
        PC = 32'h0000_0080;
        sample();
        step();
        for (int unsigned b = 0; b < 4; b++) begin
            mem_ready = 1'b1;
            fence_i   = (b == 2);
            step();
        end
        mem_ready = 1'b0;
        fence_i   = 1'b0;
        sample();
        checks++;
        if ({stall, mem_req, instr} !== {1'b1, 1'b0, NOP}) begin
            errors++;
            $display("FAIL t5_after_fence: stall/req/instr got %b %b %h exp 1 0 %h", stall, mem_req, instr, NOP);
        end
        step();
        sample();
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h0000_0080}) begin
            errors++;
            $display("FAIL t5_rerefill: req/addr got %b %h exp 1 00000080", mem_req, mem_addr);
        end
        finish_refill(4);
        sample();
        checks++;
        if ({stall, instr} !== {1'b0, 32'hC0DE_0080}) begin
            errors++;
            $display("FAIL t5_hit: stall/instr got %b %h exp 0 c0de0080", stall, instr);
        end
        step();
        // Line 4 was loaded before the fence and must be gone.
        PC = 32'h0000_0040;
        sample();
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL t5_old_line: stall got %b exp 1", stall);
        end
        step();
        finish_refill(4);
        // Fence in IDLE: same-cycle hit still served, next cycle misses.
        PC = 32'h0000_0080;
        fence_i = 1'b1;
        sample();
        checks++;
        if ({stall, instr} !== {1'b0, 32'hC0DE_0080}) begin
            errors++;
            $display("FAIL t5_idle_fence_hit: stall/instr got %b %h exp 0 c0de0080", stall, instr);
        end
        step();
        fence_i = 1'b0;
        sample();
        checks++;
        if ({stall, mem_req} !== {1'b1, 1'b0}) begin
            errors++;
            $display("FAIL t5_idle_fence_miss: stall/req got %b %b exp 1 0", stall, mem_req);
        end
        step();
        finish_refill(4);
    endtask

    task automatic test_reset_mid_refill();
        PC = 32'h0000_00C0;
        sample();
        step();
        finish_refill(2);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_req, stall, instr} !== {1'b0, 1'b1, NOP}) begin
            errors++;
            $display("FAIL t6_async: req/stall/instr got %b %b %h exp 0 1 %h", mem_req, stall, instr, NOP);
        end
        step();
        rst = 1'b0;
        sample();
        checks++;
        if ({stall, mem_req} !== {1'b1, 1'b0}) begin
            errors++;
            $display("FAIL t6_miss: stall/req got %b %b exp 1 0", stall, mem_req);
        end
        step();
        sample();
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h0000_00C0}) begin
            errors++;
            $display("FAIL t6_restart: req/addr got %b %h exp 1 000000c0", mem_req, mem_addr);
        end
        finish_refill(4);
        PC = 32'h0000_00C4;
        sample();
        checks++;
        if ({stall, instr} !== {1'b0, 32'hC0DE_00C4}) begin
            errors++;
            $display("FAIL t6_hit: stall/instr got %b %h exp 0 c0de00c4", stall, instr);
        end
        step();
        PC = 32'h0000_0080;
        sample();
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL t6_cleared: stall got %b exp 1", stall);
        end
        step();
        finish_refill(4);
    endtask

    initial begin
        test_reset();
        test_first_fill();
        test_hit();
        test_replace();
        test_gapped();
        test_fence();
        test_reset_mid_refill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
